// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed gate
// window of sys_clk cycles and publishes the count with a one-cycle valid pulse.
// With the default gate (50e6 cycles at 50 MHz) the result reads directly in Hz.
//
// Optional feature macro: FM_OVERRANGE_EN adds the over_range output.
//
// Ports:
//   sys_clk     in   base clock, rising edge
//   rst         in   asynchronous reset, active-high
//   en          in   1 = back-to-back measurements, 0 = stop/abort
//   sig_in      in   asynchronous signal under measurement
//   freq        out  last completed edge count
//   freq_valid  out  one-cycle pulse when freq updates
//   busy        out  high while a gate window is open
//   over_range  out  (FM_OVERRANGE_EN only) last window's count saturated
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             busy
`ifdef FM_OVERRANGE_EN
  ,
  output logic             over_range
`endif
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_det;
  logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]       freq_q, freq_d;
  logic                   freq_valid_q, freq_valid_d;
`ifdef FM_OVERRANGE_EN
  logic                   over_range_q, over_range_d;
`endif

  // Synchroniser chain plus one history flop for rising-edge detection.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
`ifdef FM_OVERRANGE_EN
    over_range_d = over_range_q;
`endif
    case (state_q)
      ST_IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        if (en) state_d = ST_GATE;
      end
      ST_GATE: begin
        if (!en) begin
          // Abort: discard the partial window, leave published results alone.
          state_d    = ST_IDLE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
        end else begin
          // Saturate rather than wrap so an overload never reads as a low rate.
          if (edge_det && (edge_cnt_q != CNT_MAX)) edge_cnt_d = edge_cnt_q + 1'b1;
          if (gate_cnt_q == GATE_LAST) begin
            state_d    = ST_LATCH;
            gate_cnt_d = '0;
          end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        // Edges seen in this cycle are dropped: one dead cycle per measurement.
        freq_d       = edge_cnt_q;
        freq_valid_d = 1'b1;
`ifdef FM_OVERRANGE_EN
        over_range_d = (edge_cnt_q == CNT_MAX);
`endif
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        state_d      = en ? ST_GATE : ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
    end
  end

`ifdef FM_OVERRANGE_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) over_range_q <= 1'b0;
    else     over_range_q <= over_range_d;
  end

  assign over_range = over_range_q;
`endif

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign busy       = (state_q == ST_GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a 12-bit and a 4-bit instance share all stimulus.
// Expected counts come from a recorded history of the driven sig_in and the
// rule "a rise sampled at edge m is detected SYNC_STAGES-1 cycles later and is
// counted if detection falls inside the window's GATE_CYCLES gate cycles".
module tb_freq_meter;

  localparam int G    = 1000;
  localparam int SYNC = 2;
  localparam int MAXC = 32768;

  logic        sys_clk = 1'b0;
  logic        rst, en, sig_in;
  logic [11:0] freq_m;
  logic        valid_m, busy_m;
  logic [3:0]  freq_s;
  logic        valid_s, busy_s;
`ifdef FM_OVERRANGE_EN
  logic        ovr_m, ovr_s;
`endif

  freq_meter #(.GATE_CYCLES(G), .CNT_W(12), .SYNC_STAGES(SYNC)) u_dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .freq       (freq_m),
    .freq_valid (valid_m),
    .busy       (busy_m)
`ifdef FM_OVERRANGE_EN
    ,
    .over_range (ovr_m)
`endif
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(SYNC)) u_dut_narrow (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .freq       (freq_s),
    .freq_valid (valid_s),
    .busy       (busy_s)
`ifdef FM_OVERRANGE_EN
    ,
    .over_range (ovr_s)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int cyc;
  int pass_cnt;
  int total;
  int dbl_err;
  bit prev_valid;
  bit sig_hist [0:MAXC-1];
  int mode;     // 0 low, 1 high, 2 square wave, 3 random
  int half;
  int phase;
  int gstart;   // first GATE cycle of the window being measured
  int exp_main_last;
  int exp_small_last;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d required %0d (cycle %0d)", name, obs, exp, cyc);
  endtask

  function automatic bit gen(input int n);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return bit'(((n + phase) / half) % 2);
      default: return bit'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic set_period(input int period);
    half  = period / 2;
    phase = $urandom_range(0, period - 1);
    mode  = 2;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge, then
  // sig_in for the following edge is drawn and recorded.
  task automatic tick();
    @(posedge sys_clk);
    cyc++;
    #1;
    if (prev_valid && (valid_m === 1'b1)) dbl_err++;
    prev_valid = (valid_m === 1'b1);
    if (cyc + 1 >= MAXC) begin
      $display("FAIL cycle_budget: observed %0d required below %0d", cyc + 1, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    sig_in            = gen(cyc + 1);
    sig_hist[cyc + 1] = sig_in;
  endtask

  function automatic int model_count(input int p);
    int c = 0;
    for (int n = p; n < p + G; n++) begin
      int m = n - SYNC + 1;
      if (m >= 1 && sig_hist[m] && !sig_hist[m-1]) c++;
    end
    return c;
  endfunction

  // Run one full window starting at gstart and check its result and timing.
  task automatic measure();
    int          vcyc = -1;
    int          busy_err = 0;
    int          cnt;
    int          exp_m;
    int          exp_s;
    logic [11:0] f_m = 'x;
    logic [3:0]  f_s = 'x;
    logic        v_s = 1'bx;
`ifdef FM_OVERRANGE_EN
    logic        o_m = 1'bx;
    logic        o_s = 1'bx;
`endif
    while (cyc < gstart + G + 1) begin
      tick();
      if (cyc >= gstart && cyc < gstart + G && busy_m !== 1'b1) busy_err++;
      if (cyc == gstart + G && busy_m !== 1'b0) busy_err++;
      if (valid_m === 1'b1 && vcyc < 0) begin
        vcyc = cyc;
        f_m  = freq_m;
        f_s  = freq_s;
        v_s  = valid_s;
`ifdef FM_OVERRANGE_EN
        o_m  = ovr_m;
        o_s  = ovr_s;
`endif
      end
    end
    cnt   = model_count(gstart);
    exp_m = (cnt > 4095) ? 4095 : cnt;
    exp_s = (cnt > 15) ? 15 : cnt;
    check("valid_time", vcyc, gstart + G + 1);
    check("freq_wide", f_m, exp_m);
    check("freq_narrow", f_s, exp_s);
    check("valid_narrow", v_s, 1);
    check("busy_pattern_errors", busy_err, 0);
`ifdef FM_OVERRANGE_EN
    check("over_range_wide", o_m, (cnt >= 4095) ? 1 : 0);
    check("over_range_narrow", o_s, (cnt >= 15) ? 1 : 0);
`endif
    exp_main_last  = exp_m;
    exp_small_last = exp_s;
    gstart         = gstart + G + 1;
  endtask

  initial begin
    int n_valid;
    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
    cyc = 0; pass_cnt = 0; total = 0; dbl_err = 0; prev_valid = 1'b0;
    mode = 0; half = 1; phase = 0;

    // Reset state
    #2;
    check("reset_freq_wide", freq_m, 0);
    check("reset_valid", valid_m, 0);
    check("reset_busy", busy_m, 0);
    check("reset_freq_narrow", freq_s, 0);
`ifdef FM_OVERRANGE_EN
    check("reset_over_range", ovr_s, 0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // Input held low, then held high
    en = 1'b1;
    gstart = cyc + 1;
    measure();
    measure();
    mode = 1;
    measure();
    measure();

    // Square wave, period 10
    set_period(10);
    measure();
    measure();
    measure();

    // Abort at gate cycle 500
    while (cyc < gstart + 500) tick();
    check("abort_busy_before", busy_m, 1);
    en = 1'b0;
    tick();
    check("abort_busy_after", busy_m, 0);
    n_valid = 0;
    repeat (1200) begin
      tick();
      if (valid_m === 1'b1) n_valid++;
    end
    check("abort_no_valid", n_valid, 0);
    check("abort_freq_hold_wide", freq_m, exp_main_last);
    check("abort_freq_hold_narrow", freq_s, exp_small_last);

    // Saturation on the narrow instance, then back in range
    en = 1'b1;
    gstart = cyc + 1;
    set_period(4);
    measure();
    measure();
    set_period(100);
    measure();
    measure();

    // Reset mid-gate
    repeat (300) tick();
    mode = 0;
    rst  = 1'b1;
    #1;
    check("midreset_freq_wide", freq_m, 0);
    check("midreset_valid", valid_m, 0);
    check("midreset_busy", busy_m, 0);
    check("midreset_freq_narrow", freq_s, 0);
`ifdef FM_OVERRANGE_EN
    check("midreset_over_range", ovr_s, 0);
`endif
    repeat (4) tick();
    rst = 1'b0;
    gstart = cyc + 1;
    set_period(10);
    measure();

    // Maximum rate: toggle every cycle
    set_period(2);
    measure();
    measure();

    // Random input
    mode = 3;
    measure();
    measure();

    check("no_back_to_back_valid", dbl_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
